// File: rtl/edge_pulse_pkg.sv
// -----------------------------------------------------------------------------
// edge_pulse_pkg
// Shared definitions for the multi-channel edge detector / pulse generator.
//   mode_t     : 2-bit edge-select type
//   MODE_OFF   : no edges detected
//   MODE_RISE  : rising edges only
//   MODE_FALL  : falling edges only
//   MODE_BOTH  : rising and falling edges
// -----------------------------------------------------------------------------
package edge_pulse_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_OFF  = 2'b00;
   localparam mode_t MODE_RISE = 2'b01;
   localparam mode_t MODE_FALL = 2'b10;
   localparam mode_t MODE_BOTH = 2'b11;

endpackage : edge_pulse_pkg

// File: rtl/edge_pulse_chan.sv
// -----------------------------------------------------------------------------
// edge_pulse_chan
// One channel: resynchroniser, edge detector, pulse stretcher and saturating
// edge counter.
// Ports:
//   CLK          in   system clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   sig_in       in   asynchronous channel input
//   mode         in   edge select (off / rise / fall / both)
//   stretch_len  in   extra pulse cycles, loaded on each detected edge
//   clear        in   synchronous clear of counter and saturation flag
//   pulse_out    out  registered event pulse
//   edge_cnt     out  saturating edge count
//   cnt_sat      out  sticky saturation flag
// -----------------------------------------------------------------------------
module edge_pulse_chan
   import edge_pulse_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_W     = 4,
   parameter int CNT_W       = 16
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               sig_in,
   input  mode_t              mode,
   input  logic [PULSE_W-1:0] stretch_len,
   input  logic               clear,
   output logic               pulse_out,
   output logic [CNT_W-1:0]   edge_cnt,
   output logic               cnt_sat
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;
   logic [PULSE_W-1:0]     remain_r;
   logic                   pulse_r;
   logic [CNT_W-1:0]       cnt_r;
   logic                   sat_r;

   logic                   sync_s;
   logic                   rise_s;
   logic                   fall_s;
   logic                   edge_s;

   assign sync_s = sync_r[SYNC_STAGES-1];

   // Synchroniser chain plus the previous-value flop used for edge detection.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
         prev_r <= sync_s;
      end
   end

   // Edge qualification against the runtime mode.
   always_comb begin
      rise_s = sync_s & ~prev_r;
      fall_s = ~sync_s & prev_r;
      case (mode)
         MODE_OFF:  edge_s = 1'b0;
         MODE_RISE: edge_s = rise_s;
         MODE_FALL: edge_s = fall_s;
         MODE_BOTH: edge_s = rise_s | fall_s;
         default:   edge_s = 1'b0;
      endcase
   end

   // Pulse stretcher: an edge (re)loads the down-counter, so a retrigger
   // extends the pulse instead of producing a second one.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         remain_r <= {PULSE_W{1'b0}};
         pulse_r  <= 1'b0;
      end else if (edge_s) begin
         remain_r <= stretch_len;
         pulse_r  <= 1'b1;
      end else if (remain_r != {PULSE_W{1'b0}}) begin
         remain_r <= remain_r - {{(PULSE_W-1){1'b0}}, 1'b1};
         pulse_r  <= 1'b1;
      end else begin
         remain_r <= remain_r;
         pulse_r  <= 1'b0;
      end
   end

   // Saturating edge counter; clear wins over a simultaneous edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_r <= {CNT_W{1'b0}};
         sat_r <= 1'b0;
      end else if (clear) begin
         cnt_r <= {CNT_W{1'b0}};
         sat_r <= 1'b0;
      end else if (edge_s) begin
         if (cnt_r == {CNT_W{1'b1}}) begin
            cnt_r <= cnt_r;
            sat_r <= 1'b1;
         end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            sat_r <= sat_r;
         end
      end else begin
         cnt_r <= cnt_r;
         sat_r <= sat_r;
      end
   end

   assign pulse_out = pulse_r;
   assign edge_cnt  = cnt_r;
   assign cnt_sat   = sat_r;

endmodule : edge_pulse_chan

// File: rtl/edge_pulse_gen.sv
// -----------------------------------------------------------------------------
// edge_pulse_gen
// Multi-channel edge detector and pulse generator. Each channel is an
// independent edge_pulse_chan; this level only fans out the shared controls
// and packs the counters.
// Ports:
//   CLK          in   system clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   sig_in       in   asynchronous channel inputs, one bit per channel
//   mode         in   edge select: 00 off, 01 rising, 10 falling, 11 both
//   stretch_len  in   extra pulse cycles (pulse lasts stretch_len+1 cycles)
//   clear        in   synchronous clear of all counters and saturation flags
//   pulse_out    out  registered per-channel event pulse
//   edge_cnt     out  packed counters, channel i at [i*CNT_W +: CNT_W]
//   cnt_sat      out  per-channel sticky saturation flag
// -----------------------------------------------------------------------------
module edge_pulse_gen
   import edge_pulse_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_W     = 4,
   parameter int CNT_W       = 16
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [CHANNELS-1:0]       sig_in,
   input  mode_t                     mode,
   input  logic [PULSE_W-1:0]        stretch_len,
   input  logic                      clear,
   output logic [CHANNELS-1:0]       pulse_out,
   output logic [CHANNELS*CNT_W-1:0] edge_cnt,
   output logic [CHANNELS-1:0]       cnt_sat
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      edge_pulse_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .PULSE_W     (PULSE_W),
         .CNT_W       (CNT_W)
      ) u_chan (
         .CLK         (CLK),
         .RST_N       (RST_N),
         .sig_in      (sig_in[i]),
         .mode        (mode),
         .stretch_len (stretch_len),
         .clear       (clear),
         .pulse_out   (pulse_out[i]),
         .edge_cnt    (edge_cnt[i*CNT_W +: CNT_W]),
         .cnt_sat     (cnt_sat[i])
      );
   end

endmodule : edge_pulse_gen
